csa42_tree_pipe: RTL and testbench

- Parametrised, pipelined carry-save reduction tree built from rows of 4-2 compressor cells.
- Reduces NUM_OPS partial products (4 or 8) of WIDTH bits to a redundant Sum/Carry pair.
- Each operand has a per-transaction enable mask, and the block uses a valid/ready handshake with full backpressure.
- Sits between the partial-product generator and the final carry-propagate adder of the multiply-add datapath.

---
 rtl/csa42_tree_pipe.sv | 133 +++++++++++++
 tb/tb_csa42_tree_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa42_tree_pipe.sv
// Pipelined carry-save reduction tree of 4-2 compressor rows: NUM_OPS (4 or 8)
// masked operands become a redundant sum/carry pair, under a valid/ready handshake.

module csa42_row #(
    parameter int WIDTH = 48
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] cy
);
    logic [WIDTH-1:0] x1, cin;
    logic [WIDTH-2:0] co, cc;

    // The MSB cout and carry fall off the top, so only WIDTH-1 of each are built.
    assign x1  = a ^ b ^ c;
    assign co  = (a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                 (b[WIDTH-2:0] & c[WIDTH-2:0]);
    assign cin = {co, 1'b0};
    assign s   = x1 ^ d ^ cin;
    assign cc  = (x1[WIDTH-2:0] & d[WIDTH-2:0]) | (x1[WIDTH-2:0] & cin[WIDTH-2:0]) |
                 (d[WIDTH-2:0] & cin[WIDTH-2:0]);
    assign cy  = {cc, 1'b0};
endmodule

module csa42_tree_pipe #(
    parameter int WIDTH    = 48,
    parameter int NUM_OPS  = 8,
    parameter int PIPE_MID = 1,
    parameter int TAG_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_OPS*WIDTH-1:0]   in_ops,
    input  logic [NUM_OPS-1:0]         in_mask,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_sum,
    output logic [WIDTH-1:0]           out_carry,
    output logic [TAG_W-1:0]           out_tag
);
    localparam bit MID = (NUM_OPS == 8) && (PIPE_MID != 0);

    logic [NUM_OPS-1:0][WIDTH-1:0] ops_m;
    logic [WIDTH-1:0]              fin_s, fin_c;
    logic [TAG_W-1:0]              fin_tag;
    logic                          fin_vld, out_rdy;

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_mask
        assign ops_m[k] = in_mask[k] ? in_ops[k*WIDTH +: WIDTH] : '0;
    end

    assign out_rdy = !out_valid | out_ready;

    if (NUM_OPS == 4) begin : g_one
        csa42_row #(.WIDTH(WIDTH)) u_row (
            .a(ops_m[0]), .b(ops_m[1]), .c(ops_m[2]), .d(ops_m[3]),
            .s(fin_s), .cy(fin_c)
        );
        assign fin_vld  = in_valid;
        assign fin_tag  = in_tag;
        assign in_ready = out_rdy;
    end else begin : g_two
        logic [1:0][WIDTH-1:0] l1_s, l1_c;
        logic [3:0][WIDTH-1:0] l2_in;

        for (genvar r = 0; r < 2; r++) begin : g_l1
            csa42_row #(.WIDTH(WIDTH)) u_row (
                .a(ops_m[4*r]), .b(ops_m[4*r+1]), .c(ops_m[4*r+2]), .d(ops_m[4*r+3]),
                .s(l1_s[r]), .cy(l1_c[r])
            );
        end

        if (MID) begin : g_mid
            logic                  mid_vld, mid_rdy;
            logic [3:0][WIDTH-1:0] mid_v;
            logic [TAG_W-1:0]      mid_tag;

            assign mid_rdy = !mid_vld | out_rdy;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mid_vld <= 1'b0;
                    mid_v   <= '0;
                    mid_tag <= '0;
                end else if (mid_rdy) begin
                    mid_vld <= in_valid;
                    if (in_valid) begin
                        mid_v   <= {l1_c[1], l1_s[1], l1_c[0], l1_s[0]};
                        mid_tag <= in_tag;
                    end
                end
            end

            assign l2_in    = mid_v;
            assign fin_vld  = mid_vld;
            assign fin_tag  = mid_tag;
            assign in_ready = mid_rdy;
        end else begin : g_flat
            assign l2_in    = {l1_c[1], l1_s[1], l1_c[0], l1_s[0]};
            assign fin_vld  = in_valid;
            assign fin_tag  = in_tag;
            assign in_ready = out_rdy;
        end

        csa42_row #(.WIDTH(WIDTH)) u_l2 (
            .a(l2_in[0]), .b(l2_in[1]), .c(l2_in[2]), .d(l2_in[3]),
            .s(fin_s), .cy(fin_c)
        );
    end

    // Output register: loads whenever it is empty or being drained this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_tag   <= '0;
        end else if (out_rdy) begin
            out_valid <= fin_vld;
            if (fin_vld) begin
                out_sum   <= fin_s;
                out_carry <= fin_c;
                out_tag   <= fin_tag;
            end
        end
    end
endmodule

// File: tb/tb_csa42_tree_pipe.sv
// Scoreboard bench for csa42_tree_pipe: an 8-operand 48-bit two-stage instance
// and a 4-operand 16-bit single-stage instance, checked against a bit-level model.

module tb_csa42_tree_pipe;
    typedef logic [7:0][63:0] ops_t;
    typedef struct {
        logic [63:0] s, c, tot;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    int   cyc = 0, n_chk = 0, n_fail = 0;

    logic            v8 = 0, r8, ov8, or8 = 1;
    logic [8*48-1:0] ops8 = '0;
    logic [7:0]      mask8 = '0;
    logic [3:0]      tag8 = '0, t8;
    logic [47:0]     s8, c8;

    logic            v4 = 0, r4, ov4, or4 = 1;
    logic [4*16-1:0] ops4 = '0;
    logic [3:0]      mask4 = '0;
    logic [3:0]      tag4 = '0, t4;
    logic [15:0]     s4, c4;

    exp_t q8[$], q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csa42_tree_pipe #(.WIDTH(48), .NUM_OPS(8), .PIPE_MID(1), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_ops(ops8),
        .in_mask(mask8), .in_tag(tag8), .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_carry(c8), .out_tag(t8)
    );

    csa42_tree_pipe #(.WIDTH(16), .NUM_OPS(4), .PIPE_MID(1), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_ops(ops4),
        .in_mask(mask4), .in_tag(tag4), .out_valid(ov4), .out_ready(or4),
        .out_sum(s4), .out_carry(c4), .out_tag(t4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One compressor row, bit by bit, as two chained full-adder additions.
    function automatic void row(input logic [63:0] a, b, c, d, input int w,
                                output logic [63:0] s, cy);
        logic [1:0] p, q;
        logic       ci;
        s = '0; cy = '0; ci = 1'b0;
        for (int i = 0; i < w; i++) begin
            p = 2'(a[i]) + 2'(b[i]) + 2'(c[i]);
            q = 2'(p[0]) + 2'(d[i]) + 2'(ci);
            s[i] = q[0];
            if (i < w - 1) cy[i+1] = q[1];
            ci = p[1];
        end
    endfunction

    function automatic exp_t model(input bit sel, input ops_t op, input logic [7:0] mask);
        exp_t        e;
        ops_t        m;
        logic [63:0] wm, sa, ca, sb, cb;
        int          n, w;
        n  = sel ? 4 : 8;
        w  = sel ? 16 : 48;
        wm = (64'd1 << w) - 64'd1;
        e.tot = '0;
        for (int k = 0; k < 8; k++) begin
            m[k] = (k < n && mask[k]) ? (op[k] & wm) : 64'd0;
            e.tot += m[k];
        end
        e.tot &= wm;
        if (sel) row(m[0], m[1], m[2], m[3], w, e.s, e.c);
        else begin
            row(m[0], m[1], m[2], m[3], w, sa, ca);
            row(m[4], m[5], m[6], m[7], w, sb, cb);
            row(sa, ca, sb, cb, w, e.s, e.c);
        end
        return e;
    endfunction

    task automatic send(input bit sel, input ops_t op, input logic [7:0] mask,
                        input logic [3:0] tag, input bit lat);
        exp_t e;
        int   n_wait;
        n_wait = 0;
        @(negedge clk);
        if (sel) begin
            for (int k = 0; k < 4; k++) ops4[k*16 +: 16] = op[k][15:0];
            mask4 = mask[3:0]; tag4 = tag; v4 = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) ops8[k*48 +: 48] = op[k][47:0];
            mask8 = mask; tag8 = tag; v8 = 1'b1;
        end
        #1;
        while (!(sel ? r4 : r8) && n_wait < 50) begin
            @(negedge clk); #1;
            n_wait++;
        end
        if (n_wait >= 50) begin
            chk("in_ready_timeout", 64'(sel ? r4 : r8), 64'd1);
            v4 = 1'b0; v8 = 1'b0;
            return;
        end
        e = model(sel, op, mask);
        e.tag = tag; e.acc = cyc + 1; e.lat = lat;
        if (sel) q4.push_back(e); else q8.push_back(e);
        @(posedge clk); #1;
        if (sel) v4 = 1'b0; else v8 = 1'b0;
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 200 && (sel ? q4.size() : q8.size()) != 0; i++) @(negedge clk);
        chk(sel ? "drain4" : "drain8", 64'(sel ? q4.size() : q8.size()), 64'd0);
    endtask

    function automatic ops_t rnd_ops();
        ops_t o;
        for (int k = 0; k < 8; k++) o[k] = {$urandom, $urandom};
        return o;
    endfunction

    // Output monitors: compare on each transfer and hold-check data while stalled.
    logic        st8 = 0, st4 = 0;
    logic [47:0] hs8, hc8;
    logic [15:0] hs4, hc4;
    logic [3:0]  ht8, ht4;

    always begin
        exp_t        e;
        logic [47:0] tot;
        @(negedge clk); #2;
        if (rst) st8 = 1'b0;
        else begin
            if (st8 && ov8) begin
                chk("stable_sum8", 64'(s8), 64'(hs8));
                chk("stable_carry8", 64'(c8), 64'(hc8));
                chk("stable_tag8", 64'(t8), 64'(ht8));
            end
            st8 = ov8 && !or8; hs8 = s8; hc8 = c8; ht8 = t8;
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("spurious8", 64'(ov8), 64'd0);
                else begin
                    e = q8.pop_front();
                    tot = s8 + c8;
                    chk("sum8", 64'(s8), e.s);
                    chk("carry8", 64'(c8), e.c);
                    chk("tag8", 64'(t8), 64'(e.tag));
                    chk("invariant8", 64'(tot), e.tot);
                    chk("carry0_8", 64'(c8[0]), 64'd0);
                    if (e.lat) chk("latency8", 64'(cyc - e.acc), 64'd1);
                end
            end
        end
    end

    always begin
        exp_t        e;
        logic [15:0] tot;
        @(negedge clk); #2;
        if (rst) st4 = 1'b0;
        else begin
            if (st4 && ov4) begin
                chk("stable_sum4", 64'(s4), 64'(hs4));
                chk("stable_carry4", 64'(c4), 64'(hc4));
                chk("stable_tag4", 64'(t4), 64'(ht4));
            end
            st4 = ov4 && !or4; hs4 = s4; hc4 = c4; ht4 = t4;
            if (ov4 && or4) begin
                if (q4.size() == 0) chk("spurious4", 64'(ov4), 64'd0);
                else begin
                    e = q4.pop_front();
                    tot = s4 + c4;
                    chk("sum4", 64'(s4), e.s);
                    chk("carry4", 64'(c4), e.c);
                    chk("tag4", 64'(t4), 64'(e.tag));
                    chk("invariant4", 64'(tot), e.tot);
                    chk("carry0_4", 64'(c4[0]), 64'd0);
                    if (e.lat) chk("latency4", 64'(cyc - e.acc), 64'd0);
                end
            end
        end
    end

    initial begin
        ops_t op;
        #1;
        chk("rst_ov8", 64'(ov8), 0); chk("rst_sum8", 64'(s8), 0);
        chk("rst_carry8", 64'(c8), 0); chk("rst_tag8", 64'(t8), 0);
        chk("rst_ir8", 64'(r8), 1); chk("rst_ov4", 64'(ov4), 0);
        chk("rst_ir4", 64'(r4), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) op[k] = 64'd1;
        send(0, op, 8'hFF, 4'd3, 1);
        drain(0);
        for (int k = 0; k < 8; k++) op[k] = 64'hFFFF_FFFF_FFFF;
        send(0, op, 8'hFF, 4'd1, 1);
        for (int k = 0; k < 8; k++) op[k] = 64'(k + 1);
        send(0, op, 8'h0F, 4'd2, 1);
        send(0, op, 8'h00, 4'd4, 1);
        drain(0);

        for (int i = 0; i < 10; i++) send(0, rnd_ops(), 8'($urandom), 4'(i), 1);
        drain(0);

        @(negedge clk); or8 = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send(0, rnd_ops(), 8'($urandom), 4'(i), 0);
            begin
                repeat (3) @(negedge clk);
                #1 chk("bp_in_ready_low", 64'(r8), 64'd0);
                repeat (2) @(negedge clk);
                or8 = 1'b1;
            end
        join
        drain(0);

        for (int k = 0; k < 8; k++) op[k] = 64'(16 * k + 5);
        send(0, op, 8'hFF, 4'd9, 0);
        send(0, op, 8'hF0, 4'd10, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ov8", 64'(ov8), 0); chk("mid_rst_sum8", 64'(s8), 0);
        chk("mid_rst_carry8", 64'(c8), 0); chk("mid_rst_tag8", 64'(t8), 0);
        chk("mid_rst_ir8", 64'(r8), 1);
        q8.delete();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 chk("post_rst_ov8", 64'(ov8), 0);
        end
        for (int k = 0; k < 8; k++) op[k] = 64'(1000 * k + 7);
        send(0, op, 8'hA5, 4'd6, 1);
        drain(0);

        op = '0;
        op[0] = 64'h1234; op[1] = 64'hFFFF; op[2] = 64'h0001; op[3] = 64'h8000;
        send(1, op, 8'h0F, 4'd7, 1);
        drain(1);
        for (int i = 0; i < 20; i++) send(1, rnd_ops(), 8'($urandom), 4'(i), 1);
        drain(1);
        for (int k = 0; k < 4; k++) op[k] = 64'hFFFF;
        send(1, op, 8'h0F, 4'd8, 1);
        send(1, op, 8'h00, 4'd9, 1);
        drain(1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
